multicore_mem_arbiter: RTL and testbench
========================================

// Module: multicore_mem_arbiter
// PURPOSE
//  Parametrised successor to the single-port memory controller: arbitrates NCPU cache pairs (I+D) onto one RAM port.
//  Sits between the per-CPU caches and the cpu_ram interface in the multicore top level.
//  Round-robin fairness across CPUs, data-over-instruction priority within a CPU, abort on request withdrawal,
//  and a watchdog for stuck RAM accesses.
// PARAMETERS
//  NCPU      2    number of CPUs (1..8); each CPU has one I source and one D source
//  AW        32   address width
//  DW        32   data width
//  WD_CYCLES 255  RAM cycles allowed per access before the watchdog fires (1..65535)
// PORTS
//  CLK        in   1         clock, rising edge
//  RST        in   1         synchronous, active-high reset
//  iREN       in   NCPU      instruction read request, per CPU
//  iaddr      in   NCPU*AW   instruction address; CPU c occupies [c*AW +: AW]
//  dREN       in   NCPU      data read request
//  dWEN       in   NCPU      data write request (dREN&dWEN on one CPU counts as a write)
//  daddr      in   NCPU*AW   data address
//  dstore     in   NCPU*DW   data write value
//  iwait      out  NCPU      1 = instruction request not yet done
//  dwait      out  NCPU      1 = data request not yet done
//  iload      out  NCPU*DW   instruction read data; valid in the cycle iwait[c] drops
//  dload      out  NCPU*DW   data read data; valid in the cycle dwait[c] drops
//  ramaddr    out  AW        RAM address
//  ramstore   out  DW        RAM write data
//  ramREN     out  1         RAM read enable
//  ramWEN     out  1         RAM write enable
//  ramload    in   DW        RAM read data
//  ramstate   in   2         FREE=0 BUSY=1 ACCESS=2 ERROR=3
//  wd_timeout out  1         sticky flag, set when the watchdog fires; cleared only by RST
// BEHAVIOUR
//  Reset values: state=IDLE, rr_ptr=0, grant cleared, ramREN=ramWEN=0, ramaddr=ramstore=0, wd_timeout=0.
//   All iwait/dwait outputs mirror the request inputs (a waiting request shows wait=1).
//  Request handling:
//   - waits are combinational: wait[src] = req[src] & ~(granted src & ramstate==ACCESS & state==XFER).
//   - loads are combinational: iload[c] = dload[c] = ramload for every c (fanout); a load is qualified by its wait.
//  FSM:
//   IDLE: if any request is pending, latch the winner (CPU index, I/D select, R/W) into grant registers,
//    then go to XFER. RAM enables stay 0 in IDLE.
//   XFER: drive ramaddr/ramstore/ramREN/ramWEN from the granted source's live inputs.
//    - ramstate==ACCESS: drop that source's wait this cycle; next state IDLE;
//      rr_ptr <= (granted CPU + 1) mod NCPU.
//    - ramstate==ERROR: stay in XFER and reissue (enables remain asserted); the watchdog keeps counting.
//    - the granted request deasserts before ACCESS: abort; next state IDLE with no ack; rr_ptr unchanged.
//    - watchdog counter reaches WD_CYCLES: set wd_timeout; force an ack (wait low one cycle, load=ramload);
//      next state IDLE; rr_ptr advances.
//  Latency: a request arriving at cycle 0 with the bus idle drives RAM from cycle 1.
//   Wait drops in the first XFER cycle that shows ACCESS. The minimum request-to-ack latency is 1 cycle.
//   One IDLE bubble separates back-to-back grants.
//  Arbitration: scan CPUs from rr_ptr upward with wrap. The first CPU with any request wins.
//   Within that CPU, D (read or write) beats I.
//   A CPU whose D was just served is skipped by the rotation, even if its I is pending.
//  Watchdog counter: clog2(WD_CYCLES+1) bits, cleared on entry to XFER. Saturates; never wraps.
//  A mid-operation RST returns to IDLE next edge; any in-flight RAM access is dropped with no ack.
//  NCPU==1 degenerates to D-priority with no rotation.
// STRUCTURE
//  mem_arb_pkg: ramstate_t enum {FREE,BUSY,ACCESS,ERROR}, arb_state_t {IDLE,XFER}, word_t, grant_t struct {cpu,isdata,iswrite}.
//  Sub-module rr_priority_picker #(N): req vector + ptr -> one-hot grant + index; combinational, reused by other arbiters.
//  Top: grant registers, FSM, watchdog, output muxes.
// TESTING
//  Single D read, CPU0, daddr=0x40, ACCESS after 3 BUSY -> ramREN on cycles 1..4, dwait[0] low in cycle 4, dload=ramload.
//  Simultaneous iREN[0], dREN[0], iREN[1] with RAM at ACCESS immediately -> service order D0, I1, I0.
//  Write dWEN[1], daddr=0x80, dstore=0xDEADBEEF -> ramWEN=1, ramaddr=0x80, ramstore=0xDEADBEEF, dwait[1] drops on ACCESS.
//  CPU0 withdraws dREN during BUSY -> next cycle IDLE, ramREN=0, no ack, rr_ptr stays 0.
//  ramstate stuck at BUSY, WD_CYCLES=8 -> forced ack in the 8th XFER cycle, wd_timeout=1 and held until RST.
//  RST asserted during XFER with ERROR -> next cycle IDLE, enables 0, wd_timeout=0, rr_ptr=0.

Source files
------------

// File: rtl/multicore_mem_arbiter_pkg.sv
// Shared types for the multicore memory arbiter: RAM handshake states,
// arbiter FSM states and the latched grant record.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BUSY   = 2'd1,
        ACCESS = 2'd2,
        ERROR  = 2'd3
    } ramstate_t;

    typedef enum logic {
        IDLE = 1'b0,
        XFER = 1'b1
    } arb_state_t;

    localparam int MAX_CPU   = 8;
    localparam int CPU_IDX_W = 3;

    typedef logic [31:0] word_t;

    typedef struct packed {
        logic [CPU_IDX_W-1:0] cpu;
        logic                 isdata;
        logic                 iswrite;
    } grant_t;

    // Index width that stays at least one bit wide for a single requester.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/multicore_mem_arbiter_picker.sv
// Round-robin picker: the first requester at or after ptr (with wrap) wins.
// Purely combinational so other arbiters can reuse it.
module rr_priority_picker
    import mem_arb_pkg::*;
#(
    parameter int N = 2
) (
    input  logic [N-1:0]              req,
    input  logic [idx_width(N)-1:0]   ptr,
    output logic [N-1:0]              grant,
    output logic [idx_width(N)-1:0]   idx,
    output logic                      valid
);

    localparam int IW = idx_width(N);

    logic [N-1:0] rot;
    logic [IW:0]  sum;
    logic         found;

    // Rotate so that bit 0 is the pointer position, then take the lowest set bit.
    always_comb begin
        rot   = N'({req, req} >> ptr);
        sum   = '0;
        idx   = '0;
        found = 1'b0;
        grant = '0;
        for (int k = 0; k < N; k++) begin
            if (!found && rot[k]) begin
                found = 1'b1;
                sum   = {1'b0, ptr} + (IW+1)'(k);
                idx   = (sum >= (IW+1)'(N)) ? IW'(sum - (IW+1)'(N)) : IW'(sum);
            end
        end
        for (int j = 0; j < N; j++) begin
            grant[j] = found && (idx == IW'(j));
        end
    end

    assign valid = found;

endmodule

// File: rtl/multicore_mem_arbiter.sv
// Arbitrates NCPU instruction/data cache pairs onto a single RAM port with
// round-robin fairness, data-over-instruction priority, abort and watchdog.
module multicore_mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int NCPU      = 2,
    parameter int AW        = 32,
    parameter int DW        = 32,
    parameter int WD_CYCLES = 255
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic [NCPU-1:0]    iREN,
    input  logic [NCPU*AW-1:0] iaddr,
    input  logic [NCPU-1:0]    dREN,
    input  logic [NCPU-1:0]    dWEN,
    input  logic [NCPU*AW-1:0] daddr,
    input  logic [NCPU*DW-1:0] dstore,
    output logic [NCPU-1:0]    iwait,
    output logic [NCPU-1:0]    dwait,
    output logic [NCPU*DW-1:0] iload,
    output logic [NCPU*DW-1:0] dload,
    output logic [AW-1:0]      ramaddr,
    output logic [DW-1:0]      ramstore,
    output logic               ramREN,
    output logic               ramWEN,
    input  logic [DW-1:0]      ramload,
    input  logic [1:0]         ramstate,
    output logic               wd_timeout
);

    localparam int CW  = idx_width(NCPU);
    localparam int WDW = $clog2(WD_CYCLES + 1);
    localparam logic [WDW-1:0] WD_LIMIT = WDW'(WD_CYCLES);

    arb_state_t      state;
    grant_t          grant;
    logic [CW-1:0]   rr_ptr;
    logic [WDW-1:0]  wd_cnt;

    logic [NCPU-1:0] dreq;
    logic [NCPU-1:0] any_req;
    logic [NCPU-1:0] pick_onehot;
    logic [CW-1:0]   pick_idx;
    logic            pick_valid;

    ramstate_t       rs;
    logic            in_xfer;
    logic            live_req;
    logic [AW-1:0]   live_addr;
    logic [DW-1:0]   live_store;
    logic [WDW-1:0]  wd_next;
    logic            wd_hit;
    logic            ack;
    logic [CW-1:0]   rr_after;

    assign dreq    = dREN | dWEN;
    assign any_req = iREN | dreq;
    assign rs      = ramstate_t'(ramstate);
    assign in_xfer = (state == XFER);

    rr_priority_picker #(.N(NCPU)) picker (
        .req   (any_req),
        .ptr   (rr_ptr),
        .grant (pick_onehot),
        .idx   (pick_idx),
        .valid (pick_valid)
    );

    // The granted source is followed live, so a withdrawn request is seen immediately.
    always_comb begin
        live_req   = 1'b0;
        live_addr  = '0;
        live_store = '0;
        for (int c = 0; c < NCPU; c++) begin
            if (grant.cpu == CPU_IDX_W'(c)) begin
                if (grant.isdata) begin
                    live_req   = dreq[c];
                    live_addr  = daddr[c*AW +: AW];
                    live_store = dstore[c*DW +: DW];
                end else begin
                    live_req  = iREN[c];
                    live_addr = iaddr[c*AW +: AW];
                end
            end
        end
    end

    assign wd_next  = (wd_cnt == WD_LIMIT) ? wd_cnt : wd_cnt + WDW'(1);
    assign wd_hit   = (wd_next == WD_LIMIT);
    assign ack      = in_xfer && ((rs == ACCESS) || wd_hit);
    assign rr_after = (grant.cpu == CPU_IDX_W'(NCPU - 1)) ? '0
                                                          : CW'(grant.cpu + CPU_IDX_W'(1));

    always_comb begin
        iwait = '0;
        dwait = '0;
        for (int c = 0; c < NCPU; c++) begin
            iwait[c] = iREN[c] & ~(ack & (grant.cpu == CPU_IDX_W'(c)) & ~grant.isdata);
            dwait[c] = dreq[c] & ~(ack & (grant.cpu == CPU_IDX_W'(c)) & grant.isdata);
        end
    end

    assign iload    = {NCPU{ramload}};
    assign dload    = {NCPU{ramload}};
    assign ramaddr  = in_xfer ? live_addr : '0;
    assign ramstore = in_xfer ? live_store : '0;
    assign ramREN   = in_xfer & live_req & ~grant.iswrite;
    assign ramWEN   = in_xfer & live_req & grant.iswrite;

    // Withdrawal is checked before ACCESS so an abandoned access never advances the rotation.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state      <= IDLE;
            grant      <= '0;
            rr_ptr     <= '0;
            wd_cnt     <= '0;
            wd_timeout <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (pick_valid) begin
                        grant.cpu     <= CPU_IDX_W'(pick_idx);
                        grant.isdata  <= |(pick_onehot & dreq);
                        grant.iswrite <= |(pick_onehot & dWEN);
                        wd_cnt        <= '0;
                        state         <= XFER;
                    end
                end
                XFER: begin
                    if (!live_req) begin
                        state <= IDLE;
                    end else if (rs == ACCESS) begin
                        state  <= IDLE;
                        rr_ptr <= rr_after;
                    end else if (wd_hit) begin
                        wd_timeout <= 1'b1;
                        state      <= IDLE;
                        rr_ptr     <= rr_after;
                    end else begin
                        wd_cnt <= wd_next;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_multicore_mem_arbiter.sv
// Self-checking bench for multicore_mem_arbiter: directed scenarios plus a
// randomized run against a transaction-level arbitration model.
module tb_multicore_mem_arbiter;

    localparam int NCPU = 2;
    localparam int AW   = 32;
    localparam int DW   = 32;
    localparam int WD   = 8;

    localparam logic [1:0] RS_FREE   = 2'd0;
    localparam logic [1:0] RS_BUSY   = 2'd1;
    localparam logic [1:0] RS_ACCESS = 2'd2;
    localparam logic [1:0] RS_ERROR  = 2'd3;

    logic               CLK = 1'b0;
    logic               RST;
    logic [NCPU-1:0]    iREN, dREN, dWEN;
    logic [NCPU*AW-1:0] iaddr, daddr;
    logic [NCPU*DW-1:0] dstore;
    logic [NCPU-1:0]    iwait, dwait;
    logic [NCPU*DW-1:0] iload, dload;
    logic [AW-1:0]      ramaddr;
    logic [DW-1:0]      ramstore;
    logic               ramREN, ramWEN;
    logic [DW-1:0]      ramload;
    logic [1:0]         ramstate;
    logic               wd_timeout;

    int tests_run    = 0;
    int tests_failed = 0;

    multicore_mem_arbiter #(.NCPU(NCPU), .AW(AW), .DW(DW), .WD_CYCLES(WD)) dut (
        .CLK        (CLK),
        .RST        (RST),
        .iREN       (iREN),
        .iaddr      (iaddr),
        .dREN       (dREN),
        .dWEN       (dWEN),
        .daddr      (daddr),
        .dstore     (dstore),
        .iwait      (iwait),
        .dwait      (dwait),
        .iload      (iload),
        .dload      (dload),
        .ramaddr    (ramaddr),
        .ramstore   (ramstore),
        .ramREN     (ramREN),
        .ramWEN     (ramWEN),
        .ramload    (ramload),
        .ramstate   (ramstate),
        .wd_timeout (wd_timeout)
    );

    always #5 CLK = ~CLK;

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic clear_inputs();
        iREN     = '0;
        dREN     = '0;
        dWEN     = '0;
        iaddr    = '0;
        daddr    = '0;
        dstore   = '0;
        ramload  = '0;
        ramstate = RS_FREE;
    endtask

    task automatic do_reset();
        RST = 1'b1;
        clear_inputs();
        repeat (2) @(posedge CLK);
        #1;
        RST = 1'b0;
    endtask

    task automatic test_reset();
        RST = 1'b1;
        clear_inputs();
        iREN = 2'b01;
        dREN = 2'b10;
        iaddr = {32'h1111_0000, 32'h2222_0000};
        repeat (2) step();
        @(negedge CLK);
        tests_run++;
        if ({ramREN, ramWEN} !== 2'b00) begin
            tests_failed++;
            $display("[TB] FAIL reset_enables: got %b expected 00", {ramREN, ramWEN});
        end
        tests_run++;
        if ({ramaddr, ramstore} !== 64'h0) begin
            tests_failed++;
            $display("[TB] FAIL reset_bus: got %h expected 0", {ramaddr, ramstore});
        end
        tests_run++;
        if (wd_timeout !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL reset_wd: got %b expected 0", wd_timeout);
        end
        tests_run++;
        if ({iwait, dwait} !== 4'b0110) begin
            tests_failed++;
            $display("[TB] FAIL reset_waits: got %b expected 0110", {iwait, dwait});
        end
        step();
        RST = 1'b0;
        clear_inputs();
    endtask

    task automatic test_single_read();
        logic exp_w;
        do_reset();
        dREN[0] = 1'b1;
        daddr[31:0] = 32'h40;
        @(negedge CLK);
        tests_run++;
        if ({dwait[0], ramREN} !== 2'b10) begin
            tests_failed++;
            $display("[TB] FAIL rd_idle: got %b expected 10", {dwait[0], ramREN});
        end
        step();
        for (int k = 1; k <= 4; k++) begin
            ramstate = (k == 4) ? RS_ACCESS : RS_BUSY;
            ramload  = $urandom;
            exp_w    = (k != 4);
            @(negedge CLK);
            tests_run++;
            if ({ramREN, ramWEN, ramaddr} !== {2'b10, 32'h40}) begin
                tests_failed++;
                $display("[TB] FAIL rd_drive c%0d: got %b/%h expected 10/00000040", k, {ramREN, ramWEN}, ramaddr);
            end
            tests_run++;
            if (dwait[0] !== exp_w) begin
                tests_failed++;
                $display("[TB] FAIL rd_wait c%0d: got %b expected %b", k, dwait[0], exp_w);
            end
            if (k == 4) begin
                tests_run++;
                if (dload[31:0] !== ramload || iload[63:32] !== ramload) begin
                    tests_failed++;
                    $display("[TB] FAIL rd_load: got %h/%h expected %h", dload[31:0], iload[63:32], ramload);
                end
            end
            step();
        end
        dREN = '0;
        ramstate = RS_FREE;
        @(negedge CLK);
        tests_run++;
        if (ramREN !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL rd_after: got %b expected 0", ramREN);
        end
        step();
    endtask

    task automatic test_order();
        int          n_ack;
        int          ack_src[3];
        int          ack_cyc[3];
        logic [31:0] ack_addr[3];
        int          exp_src[3];
        int          exp_cyc[3];
        logic [31:0] exp_addr[3];
        logic [1:0]  drop_i, drop_d;
        exp_src  = '{1, 2, 0};
        exp_cyc  = '{1, 3, 5};
        exp_addr = '{32'h300, 32'h200, 32'h100};
        n_ack = 0;
        do_reset();
        iREN  = 2'b11;
        dREN  = 2'b01;
        iaddr = {32'h200, 32'h100};
        daddr = {32'h0, 32'h300};
        ramstate = RS_ACCESS;
        for (int cyc = 0; cyc < 12; cyc++) begin
            @(negedge CLK);
            drop_i = '0;
            drop_d = '0;
            for (int c = 0; c < NCPU; c++) begin
                if (dREN[c] && !dwait[c] && n_ack < 3) begin
                    ack_src[n_ack] = 2 * c + 1;
                    ack_cyc[n_ack] = cyc;
                    ack_addr[n_ack] = ramaddr;
                    n_ack++;
                    drop_d[c] = 1'b1;
                end
                if (iREN[c] && !iwait[c] && n_ack < 3) begin
                    ack_src[n_ack] = 2 * c;
                    ack_cyc[n_ack] = cyc;
                    ack_addr[n_ack] = ramaddr;
                    n_ack++;
                    drop_i[c] = 1'b1;
                end
            end
            step();
            iREN = iREN & ~drop_i;
            dREN = dREN & ~drop_d;
        end
        tests_run++;
        if (n_ack != 3) begin
            tests_failed++;
            $display("[TB] FAIL order_count: got %0d acks expected 3", n_ack);
        end
        for (int k = 0; k < n_ack; k++) begin
            tests_run++;
            if (ack_src[k] != exp_src[k] || ack_cyc[k] != exp_cyc[k] || ack_addr[k] !== exp_addr[k]) begin
                tests_failed++;
                $display("[TB] FAIL order_%0d: got src%0d cyc%0d addr %h expected src%0d cyc%0d addr %h", k, ack_src[k], ack_cyc[k], ack_addr[k], exp_src[k], exp_cyc[k], exp_addr[k]);
            end
        end
        clear_inputs();
    endtask

    task automatic test_write();
        do_reset();
        dWEN[1] = 1'b1;
        daddr[63:32]  = 32'h80;
        dstore[63:32] = 32'hDEAD_BEEF;
        ramstate = RS_BUSY;
        @(negedge CLK);
        tests_run++;
        if ({dwait[1], ramWEN} !== 2'b10) begin
            tests_failed++;
            $display("[TB] FAIL wr_idle: got %b expected 10", {dwait[1], ramWEN});
        end
        step();
        @(negedge CLK);
        tests_run++;
        if ({ramREN, ramWEN, ramaddr, ramstore, dwait[1]} !== {2'b01, 32'h80, 32'hDEAD_BEEF, 1'b1}) begin
            tests_failed++;
            $display("[TB] FAIL wr_drive: got en %b addr %h data %h wait %b expected en 01 addr 00000080 data deadbeef wait 1", {ramREN, ramWEN}, ramaddr, ramstore, dwait[1]);
        end
        step();
        ramstate = RS_ACCESS;
        @(negedge CLK);
        tests_run++;
        if ({dwait[1], ramWEN} !== 2'b01) begin
            tests_failed++;
            $display("[TB] FAIL wr_ack: got %b expected 01", {dwait[1], ramWEN});
        end
        step();
        clear_inputs();
    endtask

    task automatic test_abort();
        do_reset();
        dREN[0] = 1'b1;
        daddr[31:0] = 32'h44;
        iaddr = {32'h210, 32'h110};
        ramstate = RS_BUSY;
        @(negedge CLK);
        step();
        @(negedge CLK);
        tests_run++;
        if ({ramREN, ramaddr} !== {1'b1, 32'h44}) begin
            tests_failed++;
            $display("[TB] FAIL abort_drive: got %b/%h expected 1/00000044", ramREN, ramaddr);
        end
        step();
        dREN[0] = 1'b0;
        @(negedge CLK);
        step();
        iREN = 2'b11;
        @(negedge CLK);
        tests_run++;
        if ({ramREN, ramWEN, iwait} !== 4'b0011) begin
            tests_failed++;
            $display("[TB] FAIL abort_idle: got %b expected 0011", {ramREN, ramWEN, iwait});
        end
        step();
        ramstate = RS_ACCESS;
        @(negedge CLK);
        tests_run++;
        if ({iwait, ramaddr} !== {2'b10, 32'h110}) begin
            tests_failed++;
            $display("[TB] FAIL abort_rr: got %b/%h expected 10/00000110", iwait, ramaddr);
        end
        step();
        clear_inputs();
    endtask

    task automatic test_watchdog();
        logic exp_w;
        do_reset();
        dREN[1] = 1'b1;
        daddr[63:32] = 32'h55;
        ramstate = RS_BUSY;
        @(negedge CLK);
        step();
        for (int k = 1; k <= WD; k++) begin
            ramload = $urandom;
            exp_w = (k != WD);
            @(negedge CLK);
            tests_run++;
            if ({dwait[1], wd_timeout} !== {exp_w, 1'b0}) begin
                tests_failed++;
                $display("[TB] FAIL wd_wait c%0d: got %b expected %b0", k, {dwait[1], wd_timeout}, exp_w);
            end
            if (k == WD) begin
                tests_run++;
                if (dload[63:32] !== ramload) begin
                    tests_failed++;
                    $display("[TB] FAIL wd_load: got %h expected %h", dload[63:32], ramload);
                end
            end
            step();
        end
        dREN = '0;
        @(negedge CLK);
        tests_run++;
        if ({wd_timeout, ramREN} !== 2'b10) begin
            tests_failed++;
            $display("[TB] FAIL wd_fire: got %b expected 10", {wd_timeout, ramREN});
        end
        repeat (4) step();
        @(negedge CLK);
        tests_run++;
        if (wd_timeout !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL wd_sticky: got %b expected 1", wd_timeout);
        end
        step();
        clear_inputs();
    endtask

    task automatic test_reset_mid();
        do_reset();
        dREN[0] = 1'b1;
        daddr[31:0] = 32'h60;
        iaddr = {32'h900, 32'h500};
        ramstate = RS_BUSY;
        for (int k = 0; k <= WD; k++) begin
            @(negedge CLK);
            step();
        end
        dREN = '0;
        iREN[1] = 1'b1;
        ramstate = RS_ERROR;
        @(negedge CLK);
        tests_run++;
        if (wd_timeout !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL rm_wd_set: got %b expected 1", wd_timeout);
        end
        step();
        @(negedge CLK);
        step();
        @(negedge CLK);
        tests_run++;
        if ({ramREN, ramWEN, ramaddr, iwait[1]} !== {2'b10, 32'h900, 1'b1}) begin
            tests_failed++;
            $display("[TB] FAIL rm_reissue: got en %b addr %h wait %b expected en 10 addr 00000900 wait 1", {ramREN, ramWEN}, ramaddr, iwait[1]);
        end
        step();
        RST = 1'b1;
        @(negedge CLK);
        step();
        RST = 1'b0;
        iREN = 2'b11;
        ramstate = RS_BUSY;
        @(negedge CLK);
        tests_run++;
        if ({ramREN, ramWEN, wd_timeout, iwait} !== 5'b00011) begin
            tests_failed++;
            $display("[TB] FAIL rm_after_rst: got %b expected 00011", {ramREN, ramWEN, wd_timeout, iwait});
        end
        step();
        ramstate = RS_ACCESS;
        @(negedge CLK);
        tests_run++;
        if ({iwait, ramaddr} !== {2'b10, 32'h500}) begin
            tests_failed++;
            $display("[TB] FAIL rm_rr_zero: got %b/%h expected 10/00000500", iwait, ramaddr);
        end
        step();
        clear_inputs();
    endtask

    // Sources are numbered cpu*2 + (1 for data, 0 for instruction).
    task automatic test_random(input int ncycles);
        bit          pend[4];
        int          remain[4];
        logic [31:0] addr_s[4];
        logic [31:0] store_s[4];
        bit          wr_s[4];
        bit          both_s[4];
        int          rr, cur, left, c;
        bit          busy, ack_now, found;
        logic [1:0]  exp_i, exp_d;
        logic [31:0] got_load;
        do_reset();
        rr = 0;
        cur = 0;
        left = 0;
        busy = 1'b0;
        for (int s = 0; s < 4; s++) begin
            pend[s] = 1'b0;
            remain[s] = int'($urandom_range(4, 12));
            addr_s[s] = '0;
            store_s[s] = '0;
            wr_s[s] = 1'b0;
            both_s[s] = 1'b0;
        end
        for (int cyc = 0; cyc < ncycles; cyc++) begin
            for (int s = 0; s < 4; s++) begin
                if (!pend[s] && remain[s] > 0 && $urandom_range(0, 2) == 0) begin
                    pend[s] = 1'b1;
                    addr_s[s] = $urandom;
                    store_s[s] = $urandom;
                    wr_s[s] = (s % 2 == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
                    both_s[s] = wr_s[s] & 1'($urandom_range(0, 1));
                end
            end
            for (int k = 0; k < NCPU; k++) begin
                iREN[k] = pend[2*k];
                iaddr[k*AW +: AW] = addr_s[2*k];
                dWEN[k] = pend[2*k+1] & wr_s[2*k+1];
                dREN[k] = pend[2*k+1] & (~wr_s[2*k+1] | both_s[2*k+1]);
                daddr[k*AW +: AW] = addr_s[2*k+1];
                dstore[k*DW +: DW] = store_s[2*k+1];
            end
            ack_now = busy && (left == 0);
            ramstate = !busy ? RS_FREE : (left == 0 ? RS_ACCESS : RS_BUSY);
            ramload = $urandom;
            @(negedge CLK);
            for (int k = 0; k < NCPU; k++) begin
                exp_i[k] = pend[2*k]   && !(ack_now && cur == 2*k);
                exp_d[k] = pend[2*k+1] && !(ack_now && cur == 2*k+1);
            end
            tests_run++;
            if ({iwait, dwait} !== {exp_i, exp_d}) begin
                tests_failed++;
                $display("[TB] FAIL rnd_wait c%0d: got %b expected %b", cyc, {iwait, dwait}, {exp_i, exp_d});
            end
            tests_run++;
            if ({ramREN, ramWEN} !== {busy && !wr_s[cur], busy && wr_s[cur]}) begin
                tests_failed++;
                $display("[TB] FAIL rnd_en c%0d: got %b expected %b", cyc, {ramREN, ramWEN}, {busy && !wr_s[cur], busy && wr_s[cur]});
            end
            if (busy) begin
                tests_run++;
                if (ramaddr !== addr_s[cur]) begin
                    tests_failed++;
                    $display("[TB] FAIL rnd_addr c%0d: got %h expected %h", cyc, ramaddr, addr_s[cur]);
                end
                if (wr_s[cur]) begin
                    tests_run++;
                    if (ramstore !== store_s[cur]) begin
                        tests_failed++;
                        $display("[TB] FAIL rnd_store c%0d: got %h expected %h", cyc, ramstore, store_s[cur]);
                    end
                end
            end
            if (ack_now) begin
                got_load = (cur % 2 == 1) ? dload[(cur/2)*DW +: DW] : iload[(cur/2)*DW +: DW];
                tests_run++;
                if (got_load !== ramload) begin
                    tests_failed++;
                    $display("[TB] FAIL rnd_load c%0d: got %h expected %h", cyc, got_load, ramload);
                end
            end
            if (busy) begin
                if (left == 0) begin
                    pend[cur] = 1'b0;
                    remain[cur]--;
                    rr = (cur / 2 + 1) % NCPU;
                    busy = 1'b0;
                end else begin
                    left--;
                end
            end else begin
                found = 1'b0;
                for (int k = 0; k < NCPU; k++) begin
                    c = (rr + k) % NCPU;
                    if (!found && pend[2*c+1]) begin
                        cur = 2*c + 1;
                        found = 1'b1;
                    end else if (!found && pend[2*c]) begin
                        cur = 2*c;
                        found = 1'b1;
                    end
                end
                if (found) begin
                    busy = 1'b1;
                    left = int'($urandom_range(0, 3));
                end
            end
            step();
        end
        clear_inputs();
    endtask

    initial begin
        RST = 1'b1;
        clear_inputs();
        test_reset();
        test_single_read();
        test_order();
        test_write();
        test_abort();
        test_watchdog();
        test_reset_mid();
        test_random(600);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL global_timeout: simulation still running at %0t", $time);
        $fatal(1, "[TB] simulation did not finish");
    end

endmodule
